// File: rtl/ym3438_timer_bank.sv
// Bank of NTIM independent prescaled up-counters that reload from a load register on overflow.
// Each timer raises a one-cycle overflow strobe and an optional sticky flag; irq is the OR of the flags.
module ym3438_timer_bank #(
  parameter int NTIM  = 2,
  parameter int WIDTH = 10,
  parameter int IW    = (NTIM > 1) ? $clog2(NTIM) : 1
) (
  input  logic                    MCLK,
  input  logic                    IC,
  input  logic                    tick,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [IW-1:0]           wr_idx,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [NTIM*WIDTH-1:0]   count_o,
  output logic [NTIM-1:0]         ovf_pulse,
  output logic [NTIM-1:0]         flags,
  output logic                    irq
);

  logic [WIDTH-1:0] load_q    [NTIM];
  logic [WIDTH-1:0] cnt_q     [NTIM];
  logic [3:0]       pre_cnt_q [NTIM];
  logic [3:0]       pre_q     [NTIM];
  logic [NTIM-1:0]  run_q;
  logic [NTIM-1:0]  flag_en_q;
  logic [NTIM-1:0]  flag_q;

  logic [NTIM-1:0]  ld_wr;
  logic [NTIM-1:0]  ctl_wr;
  logic [NTIM-1:0]  start;
  logic [NTIM-1:0]  step;
  logic [NTIM-1:0]  adv;
  logic [NTIM-1:0]  ovf;
  logic [NTIM-1:0]  flag_nxt;

  // Everything here looks at pre-write register values, so a write never alters the same-edge tick.
  // An out-of-range index matches no timer and is dropped.
  always_comb begin
    ld_wr    = '0;
    ctl_wr   = '0;
    start    = '0;
    step     = '0;
    adv      = '0;
    ovf      = '0;
    flag_nxt = '0;
    for (int i = 0; i < NTIM; i++) begin
      ld_wr[i]    = wr_en && !wr_sel && (int'(wr_idx) == i);
      ctl_wr[i]   = wr_en &&  wr_sel && (int'(wr_idx) == i);
      start[i]    = ctl_wr[i] && wr_data[0] && !run_q[i];
      step[i]     = run_q[i] && tick;
      adv[i]      = step[i] && (pre_cnt_q[i] == pre_q[i]);
      ovf[i]      = adv[i] && (&cnt_q[i]);
      // Overflow set beats a simultaneous clear strobe.
      flag_nxt[i] = (ovf[i] && flag_en_q[i]) || (flag_q[i] && !(ctl_wr[i] && wr_data[2]));
    end
  end

  always_ff @(posedge MCLK or posedge IC) begin
    if (IC) begin
      for (int i = 0; i < NTIM; i++) begin
        load_q[i]    <= '0;
        cnt_q[i]     <= '0;
        pre_cnt_q[i] <= '0;
        pre_q[i]     <= '0;
      end
      run_q     <= '0;
      flag_en_q <= '0;
      flag_q    <= '0;
      ovf_pulse <= '0;
      irq       <= 1'b0;
    end else begin
      for (int i = 0; i < NTIM; i++) begin
        if (ld_wr[i]) load_q[i] <= wr_data;
        if (ctl_wr[i]) begin
          run_q[i]     <= wr_data[0];
          flag_en_q[i] <= wr_data[1];
          pre_q[i]     <= wr_data[6:3];
        end
        // start needs run == 0, so it can never coincide with a count step.
        if (start[i]) begin
          cnt_q[i]     <= load_q[i];
          pre_cnt_q[i] <= '0;
        end else if (step[i]) begin
          if (adv[i]) begin
            pre_cnt_q[i] <= '0;
            cnt_q[i]     <= ovf[i] ? load_q[i] : cnt_q[i] + WIDTH'(1);
          end else begin
            pre_cnt_q[i] <= pre_cnt_q[i] + 4'd1;
          end
        end
      end
      flag_q    <= flag_nxt;
      ovf_pulse <= ovf;
      irq       <= |flag_nxt;
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NTIM; i++) count_o[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  assign flags = flag_q;

endmodule

// File: tb/tb_ym3438_timer_bank.sv
// Directed bench for ym3438_timer_bank: stimulus queues expected outputs, a monitor
// pops and compares them on the falling edge after each driven cycle.
module tb_ym3438_timer_bank;
  localparam int NTIM  = 2;
  localparam int WIDTH = 10;
  localparam int IW    = 2;  // wide enough to drive the out-of-range indices 2 and 3

  logic                  mclk = 1'b0;
  logic                  ic = 1'b1;
  logic                  tick = 1'b0;
  logic                  wr_en = 1'b0;
  logic                  wr_sel = 1'b0;
  logic [IW-1:0]         wr_idx = '0;
  logic [WIDTH-1:0]      wr_data = '0;
  logic [NTIM*WIDTH-1:0] count_o;
  logic [NTIM-1:0]       ovf_pulse;
  logic [NTIM-1:0]       flags;
  logic                  irq;

  ym3438_timer_bank #(.NTIM(NTIM), .WIDTH(WIDTH), .IW(IW)) dut (
    .MCLK(mclk), .IC(ic), .tick(tick), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_idx(wr_idx), .wr_data(wr_data), .count_o(count_o),
    .ovf_pulse(ovf_pulse), .flags(flags), .irq(irq)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    string       name;
    logic [19:0] cnt;
    logic [1:0]  ovf;
    logic [1:0]  flg;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic compare(input exp_t e);
    checks++;
    if (count_o !== e.cnt || ovf_pulse !== e.ovf || flags !== e.flg || irq !== e.irq) begin
      errors++;
      $display("FAIL %s: got count_o=%h ovf_pulse=%b flags=%b irq=%b, want count_o=%h ovf_pulse=%b flags=%b irq=%b",
               e.name, count_o, ovf_pulse, flags, irq, e.cnt, e.ovf, e.flg, e.irq);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [9:0] c1, input logic [9:0] c0,
                              input logic [1:0] o, input logic [1:0] f, input logic q);
    exp_t e;
    e.name = name; e.cnt = {c1, c0}; e.ovf = o; e.flg = f; e.irq = q;
    return e;
  endfunction

  task automatic expect_out(input string name, input logic [9:0] c1, input logic [9:0] c0,
                            input logic [1:0] o, input logic [1:0] f, input logic q);
    sb.push_back(mk(name, c1, c0, o, f, q));
  endtask

  // One driven MCLK cycle; returns 1 time unit after the rising edge with inputs idle.
  task automatic cyc(input bit t, input bit en, input bit sel, input logic [IW-1:0] idx,
                     input logic [WIDTH-1:0] d);
    tick = t; wr_en = en; wr_sel = sel; wr_idx = idx; wr_data = d;
    @(posedge mclk);
    #1;
    tick = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
  endtask

  task automatic ld(input logic [IW-1:0] idx, input logic [WIDTH-1:0] d);
    cyc(1'b0, 1'b1, 1'b0, idx, d);
  endtask
  task automatic ctl(input logic [IW-1:0] idx, input logic [WIDTH-1:0] d);
    cyc(1'b0, 1'b1, 1'b1, idx, d);
  endtask
  task automatic tk();
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge mclk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  logic [9:0] t1_tab [8];

  initial begin : stim
    t1_tab = '{10'h3FE, 10'h3FE, 10'h3FE, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FE};

    @(posedge mclk); #1;
    expect_out("reset", 10'h000, 10'h000, 2'b00, 2'b00, 1'b0);
    ic = 1'b0;

    // Timer 0 overflow with flag enabled
    ld(0, 10'h3FC);   expect_out("ld0",      10'h000, 10'h000, 2'b00, 2'b00, 1'b0);
    ctl(0, 10'h003);  expect_out("start0",   10'h000, 10'h3FC, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("t0_tick1", 10'h000, 10'h3FD, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("t0_tick2", 10'h000, 10'h3FE, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("t0_tick3", 10'h000, 10'h3FF, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("t0_ovf",   10'h000, 10'h3FC, 2'b01, 2'b01, 1'b1);
    idle();           expect_out("t0_pulse_end", 10'h000, 10'h3FC, 2'b00, 2'b01, 1'b1);
    ctl(0, 10'h002);  expect_out("t0_stop",  10'h000, 10'h3FC, 2'b00, 2'b01, 1'b1);

    // Timer 1 with prescale 3, flag disabled; timer 0 frozen and must ignore ticks
    ld(1, 10'h3FE);   expect_out("ld1",      10'h000, 10'h3FC, 2'b00, 2'b01, 1'b1);
    ctl(1, 10'h019);  expect_out("start1",   10'h3FE, 10'h3FC, 2'b00, 2'b01, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tk();
      expect_out($sformatf("t1_pre_tick%0d", k + 1), t1_tab[k], 10'h3FC,
                 (k == 7) ? 2'b10 : 2'b00, 2'b01, 1'b1);
    end
    idle();           expect_out("t1_pulse_end", 10'h3FE, 10'h3FC, 2'b00, 2'b01, 1'b1);
    ctl(1, 10'h000);  expect_out("t1_stop",  10'h3FE, 10'h3FC, 2'b00, 2'b01, 1'b1);

    // Flag clear colliding with overflow: set wins; later clear succeeds
    ctl(0, 10'h003);  expect_out("restart0", 10'h3FE, 10'h3FC, 2'b00, 2'b01, 1'b1);
    tk();             expect_out("r0_tick1", 10'h3FE, 10'h3FD, 2'b00, 2'b01, 1'b1);
    tk();             expect_out("r0_tick2", 10'h3FE, 10'h3FE, 2'b00, 2'b01, 1'b1);
    tk();             expect_out("r0_tick3", 10'h3FE, 10'h3FF, 2'b00, 2'b01, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 0, 10'h007);
    expect_out("clr_vs_ovf", 10'h3FE, 10'h3FC, 2'b01, 2'b01, 1'b1);
    ctl(0, 10'h007);  expect_out("clr0",     10'h3FE, 10'h3FC, 2'b00, 2'b00, 1'b0);

    // Load write while running applies at the next reload
    tk();             expect_out("l0_tick1", 10'h3FE, 10'h3FD, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("l0_tick2", 10'h3FE, 10'h3FE, 2'b00, 2'b00, 1'b0);
    ld(0, 10'h100);   expect_out("ld_run",   10'h3FE, 10'h3FE, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("l0_tick3", 10'h3FE, 10'h3FF, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("l0_reload_new", 10'h3FE, 10'h100, 2'b01, 2'b01, 1'b1);
    idle();           expect_out("l0_pulse_end", 10'h3FE, 10'h100, 2'b00, 2'b01, 1'b1);

    // Out-of-range indices must not touch either timer
    ctl(2, 10'h000);  expect_out("idx2_ctl", 10'h3FE, 10'h100, 2'b00, 2'b01, 1'b1);
    ld(3, 10'h055);   expect_out("idx3_ld",  10'h3FE, 10'h100, 2'b00, 2'b01, 1'b1);
    ctl(3, 10'h004);  expect_out("idx3_clr", 10'h3FE, 10'h100, 2'b00, 2'b01, 1'b1);
    tk();             expect_out("idx_still_run", 10'h3FE, 10'h101, 2'b00, 2'b01, 1'b1);

    // Bring timer 0 to 0x3FF, then hit it with an asynchronous reset and a pending tick
    ld(0, 10'h3FE);   expect_out("ld0_b",    10'h3FE, 10'h101, 2'b00, 2'b01, 1'b1);
    ctl(0, 10'h002);  expect_out("stop0_b",  10'h3FE, 10'h101, 2'b00, 2'b01, 1'b1);
    ctl(0, 10'h003);  expect_out("start0_b", 10'h3FE, 10'h3FE, 2'b00, 2'b01, 1'b1);
    tk();             expect_out("pre_rst",  10'h3FE, 10'h3FF, 2'b00, 2'b01, 1'b1);
    @(negedge mclk);
    #2;
    tick = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 0; wr_data = 10'h2AA;
    ic = 1'b1;
    #1;
    compare(mk("async_rst", 10'h000, 10'h000, 2'b00, 2'b00, 1'b0));
    @(posedge mclk); #1;
    tick = 1'b0; wr_en = 1'b0; wr_data = '0;
    expect_out("in_rst",   10'h000, 10'h000, 2'b00, 2'b00, 1'b0);
    ic = 1'b0;
    idle();           expect_out("post_rst", 10'h000, 10'h000, 2'b00, 2'b00, 1'b0);
    ctl(0, 10'h001);  expect_out("start_after_rst", 10'h000, 10'h000, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("count_after_rst", 10'h000, 10'h001, 2'b00, 2'b00, 1'b0);

    // All-ones load: overflow reloads to all-ones; flag stays clear with flag_en = 0
    ld(0, 10'h3FF);   expect_out("ld_ones",  10'h000, 10'h001, 2'b00, 2'b00, 1'b0);
    ctl(0, 10'h000);  expect_out("stop_ones",  10'h000, 10'h001, 2'b00, 2'b00, 1'b0);
    ctl(0, 10'h001);  expect_out("start_ones", 10'h000, 10'h3FF, 2'b00, 2'b00, 1'b0);
    tk();             expect_out("ovf_ones",   10'h000, 10'h3FF, 2'b01, 2'b00, 1'b0);
    idle();           expect_out("ones_pulse_end", 10'h000, 10'h3FF, 2'b00, 2'b00, 1'b0);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge mclk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ym3438_timer_bank.md
YM3438_TIMER_BANK -- requirements
Module: ym3438_timer_bank

Interface
REQ-001 Parameter NTIM, default 2: number of independent timers, 1..8.
REQ-002 Parameter WIDTH, default 10: counter and load-value width, 8..16.
REQ-003 Parameter IW, default 1: index width, equal to max(1, ceil(log2(NTIM))).
REQ-004 MCLK  in  1: the single clock; all state updates on rising edge.
REQ-005 IC  in  1: reset, asynchronous, active-high.
REQ-006 tick  in  1: count strobe, one MCLK cycle wide.
REQ-007 wr_en  in  1: register write strobe.
REQ-008 wr_sel  in  1: write target; 0 = load value, 1 = control word.
REQ-009 wr_idx  in  IW: timer index; values >= NTIM are ignored.
REQ-010 wr_data  in  WIDTH: write data.
REQ-011 count_o  out  NTIM*WIDTH: live counters; timer i occupies bits [i*WIDTH +: WIDTH].
REQ-012 ovf_pulse  out  NTIM: one-cycle overflow strobe per timer.
REQ-013 flags  out  NTIM: sticky overflow flags.
REQ-014 irq  out  1: OR of all flags.

Function
REQ-015 Control word bits: [0] run; [1] flag_en; [2] flag_clr (write-1 strobe, not stored); [6:3] pre, a 4-bit prescale; upper bits ignored.
REQ-016 Each timer shall hold: load[WIDTH], cnt[WIDTH], pre_cnt[4], run, flag_en, pre, flag.
REQ-017 A control write changing run from 0 to 1 shall, on the next edge, set cnt = load and pre_cnt = 0.
REQ-018 When run is 1 and tick is 1: if pre_cnt == pre, pre_cnt shall become 0 and cnt shall advance; otherwise pre_cnt shall increment and cnt shall hold.
REQ-019 With pre = P, cnt shall advance once every P+1 ticks.
REQ-020 Counter advance: if cnt == all-ones, cnt shall become load and overflow is raised; otherwise cnt shall become cnt + 1, with no wrap through zero.
REQ-021 On overflow, ovf_pulse[i] shall be 1 for exactly the next MCLK cycle, regardless of flag_en.
REQ-022 On overflow with flag_en = 1, flag[i] shall become 1 on the same edge.
REQ-023 While run is 0, cnt and pre_cnt shall hold, and tick shall be ignored.
REQ-024 A control write changing run from 1 to 0 shall freeze cnt; a later 0-to-1 change shall reload per REQ-017.
REQ-025 A control write with run staying 1 shall update flag_en and pre without reloading cnt.
REQ-026 A load write while running shall not disturb cnt; the new value shall apply at the next overflow reload or run restart.
REQ-027 A write coinciding with tick shall have the tick evaluated using pre-write register values; the write shall take effect on the same edge.
REQ-028 A run 0-to-1 write coinciding with tick shall perform the reload only, with no count that cycle.
REQ-029 flag_clr = 1 shall clear flag[i]; if an overflow sets the flag on the same edge, set shall win.
REQ-030 Clearing flag_en shall not clear an already-set flag.
REQ-031 irq shall be a registered output, equal to the OR of flags as updated on the same edge (zero extra latency versus flags).
REQ-032 Writes to one timer shall never affect another timer.

Reset
REQ-033 IC high shall immediately force all load, cnt, pre_cnt, run, flag_en, pre, flag, ovf_pulse and irq to 0, independent of MCLK.
REQ-034 While IC is high, writes and ticks shall be ignored.
REQ-035 After IC falls, the first MCLK edge shall operate normally.
REQ-036 IC asserted mid-count shall abort the count; no ovf_pulse shall be produced for the aborted cycle.

Verification (NTIM=2, WIDTH=10)
REQ-037 Timer 0: load = 0x3FC, then control = 0x03. After 4 ticks: cnt 0x3FD, 0x3FE, 0x3FF, then 0x3FC; ovf_pulse[0] high one cycle; flags = 01; irq = 1.
REQ-038 Timer 1: load = 0x3FE, control = 0x19 (run, pre = 3). 8 ticks shall give cnt 0x3FF after tick 4, and 0x3FE plus ovf_pulse[1] after tick 8; flags[1] stays 0 because flag_en = 0.
REQ-039 With flag[0] = 1, write control = 0x07 on the same edge as an overflow: flag[0] stays 1. A later write of 0x07 with no overflow: flag[0] = 0, irq = 0.
REQ-040 Running timer 0 at cnt 0x3FE: write load = 0x100. The next tick gives cnt 0x3FF; the following tick gives cnt 0x100.
REQ-041 Assert IC asynchronously (mid-cycle) while cnt = 0x3FF, with a tick pending: all outputs read 0 immediately, and no ovf_pulse appears after IC is released.
REQ-042 Write with wr_idx = 2 or 3 (>= NTIM): no state change in either timer.
